// File: rtl/dwt_pkg.sv
// Shared definitions for the DWT tile sequencer: default geometry, FSM state
// encoding and a counter-width helper.
package dwt_pkg;

  localparam int PIX_W     = 8;
  localparam int ROW_PIX   = 8;
  localparam int ROW_W     = PIX_W * ROW_PIX;
  localparam int TILE_ROWS = 8;
  localparam int CORE_LAT  = 2;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  typedef logic [ROW_W-1:0] row_t;

  // Width of a counter spanning 0..range-1, never narrower than one bit.
  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/dwt_tile_buf.sv
// Tile-sized row store with two write ports and two asynchronous read ports.
// Contents are not reset; the sequencer never reads a row before writing it.
module dwt_tile_buf #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  localparam int AW   = dwt_pkg::cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1,
  input  logic [AW-1:0] ra0,
  output logic [W-1:0]  rd0,
  input  logic [AW-1:0] ra1,
  output logic [W-1:0]  rd1
);

  // Sized to the full address space so every address decodes to a real entry.
  logic [W-1:0] mem_r [1 << AW];

  // Row writes; port 1 is applied last and wins a same-address collision.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_r[wa0] <= wd0;
    end
    if (we1) begin
      mem_r[wa1] <= wd1;
    end
  end

  assign rd0 = mem_r[ra0];
  assign rd1 = mem_r[ra1];

endmodule

// File: rtl/dwt_tile_sequencer.sv
// Buffers one tile, feeds row pairs to the external 2-D DWT core, captures the
// column outputs after a fixed latency and streams the transformed tile out.
module dwt_tile_sequencer #(
  parameter int PIX_W     = dwt_pkg::PIX_W,
  parameter int ROW_PIX   = dwt_pkg::ROW_PIX,
  parameter int TILE_ROWS = dwt_pkg::TILE_ROWS,
  parameter int CORE_LAT  = dwt_pkg::CORE_LAT,
  localparam int ROW_W    = PIX_W * ROW_PIX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  output logic [ROW_W-1:0] core_px1,
  output logic [ROW_W-1:0] core_px2,
  output logic             core_start,
  input  logic [ROW_W-1:0] core_col1,
  input  logic [ROW_W-1:0] core_col2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last,
  output logic             busy
);

  import dwt_pkg::*;

  localparam int RW  = cnt_w(TILE_ROWS);
  localparam int PCW = cnt_w(TILE_ROWS / 2);
  localparam int LCW = cnt_w(CORE_LAT);

  seq_state_t       state_r;
  logic [RW-1:0]    row_cnt_r;
  logic [RW-1:0]    out_cnt_r;
  logic [PCW-1:0]   pair_cnt_r;
  logic [LCW-1:0]   lat_cnt_r;
  logic             in_ready_r;
  logic             core_start_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             busy_r;
  logic [ROW_W-1:0] core_px1_r;
  logic [ROW_W-1:0] core_px2_r;
  logic [ROW_W-1:0] out_row_r;

  logic             in_fire_s;
  logic             out_fire_s;
  logic             lat_done_s;
  logic             last_in_s;
  logic             last_pair_s;
  logic             last_out_s;
  logic [PCW-1:0]   next_pair_s;
  logic [RW-1:0]    out_nxt_s;
  logic [RW-1:0]    ib_ra0_s;
  logic [RW-1:0]    ib_ra1_s;
  logic [RW-1:0]    rb_wa0_s;
  logic [RW-1:0]    rb_wa1_s;
  logic [ROW_W-1:0] ib_rd0_s;
  logic [ROW_W-1:0] ib_rd1_s;
  logic [ROW_W-1:0] rb_rd0_s;
  logic [ROW_W-1:0] rb_rd1_s;

  // Handshakes, terminal-count detects and buffer addressing.
  always_comb begin
    in_fire_s   = in_valid && in_ready_r;
    out_fire_s  = out_valid_r && out_ready;
    lat_done_s  = (state_r == WAIT) && (lat_cnt_r == LCW'(CORE_LAT - 1));
    last_in_s   = (row_cnt_r == RW'(TILE_ROWS - 1));
    last_pair_s = (pair_cnt_r == PCW'(TILE_ROWS / 2 - 1));
    last_out_s  = (out_cnt_r == RW'(TILE_ROWS - 1));
    out_nxt_s   = out_cnt_r + RW'(1);
    // The pair to present next: pair 0 when leaving LOAD, else the successor.
    if (state_r == WAIT) begin
      next_pair_s = pair_cnt_r + PCW'(1);
    end else begin
      next_pair_s = '0;
    end
    ib_ra0_s = RW'({next_pair_s, 1'b0});
    ib_ra1_s = RW'({next_pair_s, 1'b1});
    rb_wa0_s = RW'({pair_cnt_r, 1'b0});
    rb_wa1_s = RW'({pair_cnt_r, 1'b1});
  end

  dwt_tile_buf #(
    .DEPTH (TILE_ROWS),
    .W     (ROW_W)
  ) u_in_buf (
    .clk (clk),
    .we0 (in_fire_s),
    .wa0 (row_cnt_r),
    .wd0 (in_row),
    .we1 (1'b0),
    .wa1 ('0),
    .wd1 ('0),
    .ra0 (ib_ra0_s),
    .rd0 (ib_rd0_s),
    .ra1 (ib_ra1_s),
    .rd1 (ib_rd1_s)
  );

  // Port 0 reads ahead of the output pointer; port 1 is pinned to row 0.
  dwt_tile_buf #(
    .DEPTH (TILE_ROWS),
    .W     (ROW_W)
  ) u_res_buf (
    .clk (clk),
    .we0 (lat_done_s),
    .wa0 (rb_wa0_s),
    .wd0 (core_col1),
    .we1 (lat_done_s),
    .wa1 (rb_wa1_s),
    .wd1 (core_col2),
    .ra0 (out_nxt_s),
    .rd0 (rb_rd0_s),
    .ra1 ('0),
    .rd1 (rb_rd1_s)
  );

  // Sequencer FSM, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= LOAD;
      row_cnt_r    <= '0;
      out_cnt_r    <= '0;
      pair_cnt_r   <= '0;
      lat_cnt_r    <= '0;
      in_ready_r   <= 1'b0;
      core_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      busy_r       <= 1'b0;
      core_px1_r   <= '0;
      core_px2_r   <= '0;
      out_row_r    <= '0;
    end else begin
      core_start_r <= 1'b0;
      case (state_r)
        LOAD: begin
          in_ready_r <= 1'b1;
          if (in_fire_s) begin
            if (last_in_s) begin
              row_cnt_r    <= '0;
              in_ready_r   <= 1'b0;
              busy_r       <= 1'b1;
              core_start_r <= 1'b1;
              core_px1_r   <= ib_rd0_s;
              // A two-row tile writes its odd row on this very edge.
              core_px2_r   <= (TILE_ROWS == 2) ? in_row : ib_rd1_s;
              state_r      <= ISSUE;
            end else begin
              row_cnt_r <= row_cnt_r + RW'(1);
            end
          end
        end
        ISSUE: begin
          lat_cnt_r <= '0;
          state_r   <= WAIT;
        end
        WAIT: begin
          if (lat_done_s) begin
            lat_cnt_r <= '0;
            if (last_pair_s) begin
              pair_cnt_r  <= '0;
              out_valid_r <= 1'b1;
              out_last_r  <= 1'b0;
              // Row 0 is only being captured now when the tile is one pair.
              out_row_r   <= (TILE_ROWS == 2) ? core_col1 : rb_rd1_s;
              state_r     <= DRAIN;
            end else begin
              pair_cnt_r   <= next_pair_s;
              core_start_r <= 1'b1;
              core_px1_r   <= ib_rd0_s;
              core_px2_r   <= ib_rd1_s;
              state_r      <= ISSUE;
            end
          end else begin
            lat_cnt_r <= lat_cnt_r + LCW'(1);
          end
        end
        DRAIN: begin
          if (out_fire_s) begin
            if (last_out_s) begin
              out_cnt_r   <= '0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              busy_r      <= 1'b0;
              in_ready_r  <= 1'b1;
              state_r     <= LOAD;
            end else begin
              out_cnt_r  <= out_nxt_s;
              out_row_r  <= rb_rd0_s;
              out_last_r <= (out_nxt_s == RW'(TILE_ROWS - 1));
            end
          end
        end
        default: begin
          state_r     <= LOAD;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign core_px1   = core_px1_r;
  assign core_px2   = core_px2_r;
  assign core_start = core_start_r;
  assign out_valid  = out_valid_r;
  assign out_row    = out_row_r;
  assign out_last   = out_last_r;
  assign busy       = busy_r;

endmodule
